// File: rtl/ws2812_out.sv
// rtl/ws2812_out.sv - WS2812-style single-wire NRZ LED serialiser fed from sram_bus
//  clk, rst                  clock, synchronous active-high reset
//  word_count, start_address frame length in words, word address of page 0
//  page_count, clock_divisor pages per POV cycle (0 -> 1), timing scale (<< 0..3)
//  start_toggle              any edge requests a frame
//  read_address/read_request word read towards sram_bus, request held until strobe
//  read_data/read_finished_strobe  returned word, valid only in the strobe cycle
//  data_out, busy            LED line, frame-in-progress (start to end of latch gap)
module ws2812_out #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int T_BIT             = 60,
    parameter int T0H               = 17,
    parameter int T1H               = 34,
    parameter int T_LATCH           = 14400
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
    input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
    input  logic [7:0]                   page_count,
    input  logic [1:0]                   clock_divisor,
    input  logic                         start_toggle,
    output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
    output logic                         read_request,
    input  logic [15:0]                  read_data,
    input  logic                         read_finished_strobe,
    output logic                         data_out,
    output logic                         busy
);

    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND, S_UNDERRUN, S_LATCH
    } state_t;

    state_t state, state_next;

    logic          toggle_q;
    logic          pending;
    logic [7:0]    page;
    logic [7:0]    page_last;
    logic [AW-1:0] page_offset;     // page * word_count kept as a running sum
    logic [AW-1:0] lat_wc;
    logic [AW-1:0] remaining;       // words still to be fetched this frame
    logic [17:0]   lim_bit, lim_0h, lim_1h, lim_latch;
    logic [17:0]   cnt;
    logic [3:0]    bit_idx;
    logic [15:0]   shifter;
    logic [15:0]   buf_data;
    logic          buf_full;

    logic strobe_ok, bit_end, word_end, latch_end, frame_start;

    // A strobe only counts against our own outstanding request, so one that
    // lands during or just after reset is dropped.
    assign strobe_ok   = read_finished_strobe && read_request;
    assign bit_end     = (cnt == lim_bit - 18'd1);
    assign word_end    = bit_end && (bit_idx == 4'd0);
    assign latch_end   = (cnt == lim_latch - 18'd1);
    assign frame_start = (state == S_IDLE) && pending && (word_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (frame_start) state_next = S_FETCH;
            S_FETCH:    if (strobe_ok) state_next = S_SEND;
            S_SEND: begin
                if (word_end) begin
                    if (buf_full || strobe_ok) state_next = S_SEND;
                    else if (remaining != '0)  state_next = S_UNDERRUN;
                    else                       state_next = S_LATCH;
                end
            end
            S_UNDERRUN: if (strobe_ok) state_next = S_SEND;
            S_LATCH:    if (latch_end) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        read_request = 1'b0;
        data_out     = 1'b0;
        busy         = (state != S_IDLE);
        case (state)
            S_FETCH:             read_request = 1'b1;
            S_SEND, S_UNDERRUN:  read_request = (remaining != '0) && !buf_full;
            default:             read_request = 1'b0;
        endcase
        if (state == S_SEND) begin
            data_out = (cnt < (shifter[15] ? lim_1h : lim_0h));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q     <= start_toggle;
            pending      <= 1'b0;
            page         <= 8'd0;
            page_last    <= 8'd0;
            page_offset  <= '0;
            lat_wc       <= '0;
            remaining    <= '0;
            read_address <= start_address;
            lim_bit      <= 18'(T_BIT);
            lim_0h       <= 18'(T0H);
            lim_1h       <= 18'(T1H);
            lim_latch    <= 18'(T_LATCH);
            cnt          <= 18'd0;
            bit_idx      <= 4'd0;
            shifter      <= 16'd0;
            buf_data     <= 16'd0;
            buf_full     <= 1'b0;
        end else begin
            toggle_q <= start_toggle;
            // One-deep request latch: edges arriving while already pending merge.
            if (start_toggle != toggle_q) begin
                pending <= 1'b1;
            end else if (state == S_IDLE && pending) begin
                pending <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        lim_bit      <= 18'(T_BIT) << clock_divisor;
                        lim_0h       <= 18'(T0H) << clock_divisor;
                        lim_1h       <= 18'(T1H) << clock_divisor;
                        lim_latch    <= 18'(T_LATCH) << clock_divisor;
                        lat_wc       <= word_count;
                        page_last    <= (page_count == 8'd0) ? 8'd0 : page_count - 8'd1;
                        read_address <= start_address + page_offset;
                        remaining    <= word_count;
                        buf_full     <= 1'b0;
                        cnt          <= 18'd0;
                    end
                end
                S_FETCH, S_UNDERRUN: begin
                    if (strobe_ok) begin
                        shifter      <= read_data;
                        remaining    <= remaining - ADDR_ONE;
                        read_address <= read_address + ADDR_ONE;
                        cnt          <= 18'd0;
                        bit_idx      <= 4'd15;
                    end
                end
                S_SEND: begin
                    if (strobe_ok) begin
                        remaining    <= remaining - ADDR_ONE;
                        read_address <= read_address + ADDR_ONE;
                        if (!word_end) begin
                            buf_data <= read_data;
                            buf_full <= 1'b1;
                        end
                    end
                    if (bit_end) begin
                        cnt     <= 18'd0;
                        bit_idx <= bit_idx - 4'd1;   // 0 wraps to 15 for the next word
                        shifter <= shifter << 1;
                        if (bit_idx == 4'd0) begin
                            // A word returned exactly at the boundary goes straight
                            // to the shifter so there is no gap between words.
                            if (buf_full) begin
                                shifter  <= buf_data;
                                buf_full <= 1'b0;
                            end else if (strobe_ok) begin
                                shifter <= read_data;
                            end
                        end
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end
                S_LATCH: begin
                    if (latch_end) begin
                        cnt <= 18'd0;
                        if (page >= page_last) begin
                            page        <= 8'd0;
                            page_offset <= '0;
                        end else begin
                            page        <= page + 8'd1;
                            page_offset <= page_offset + lat_wc;
                        end
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_out.sv
// tb/tb_ws2812_out.sv - randomized self-checking bench for ws2812_out against a frame-level model
module tb_ws2812_out;

    localparam int TL = 600;   // shortened latch gap keeps the run short

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word_count, start_address;
    logic [7:0]  page_count;
    logic [1:0]  clock_divisor;
    logic        start_toggle;
    logic [15:0] read_address;
    logic        read_request;
    logic [15:0] read_data;
    logic        read_finished_strobe;
    logic        data_out, busy;

    logic        resp_strobe = 1'b0;
    logic [15:0] resp_data = 16'd0;
    logic        man_strobe = 1'b0;
    logic [15:0] man_data = 16'd0;
    assign read_finished_strobe = resp_strobe | man_strobe;
    assign read_data = man_strobe ? man_data : resp_data;

    always #5 clk = ~clk;

    ws2812_out #(.T_LATCH(TL)) dut (
        .clk(clk), .rst(rst), .word_count(word_count), .start_address(start_address),
        .page_count(page_count), .clock_divisor(clock_divisor), .start_toggle(start_toggle),
        .read_address(read_address), .read_request(read_request), .read_data(read_data),
        .read_finished_strobe(read_finished_strobe), .data_out(data_out), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [15:0] mem [0:65535];

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Observation records; the stimulus side only snapshots their sizes.
    int          rise_q[$];
    int          high_q[$];
    int          strobe_q[$];
    logic [15:0] addr_q[$];
    int  busy_rises = 0, busy_fall_cyc = 0, req_cycles = 0, n_reads = 0;
    int  rise_cyc = 0;
    logic prev_do = 1'b0, prev_busy = 1'b0;

    logic        resp_en = 1'b1;
    int          stall_no = -1;
    int          rd_base = 0;
    logic        rd_active = 1'b0;
    logic [15:0] rd_addr = 16'd0;
    int          rd_wait = 0;

    always @(negedge clk) begin
        if (busy && !prev_busy) busy_rises++;
        if (!busy && prev_busy) busy_fall_cyc = cyc;
        if (read_request) req_cycles++;
        if (data_out && !prev_do) begin
            rise_cyc = cyc;
            rise_q.push_back(cyc);
        end
        if (!data_out && prev_do) high_q.push_back(cyc - rise_cyc);
        prev_do   = data_out;
        prev_busy = busy;

        resp_strobe = 1'b0;
        if (rst || !resp_en) begin
            rd_active = 1'b0;
        end else if (rd_active) begin
            if (rd_wait == 0) begin
                chk("addr_hold", read_address, rd_addr);
                resp_data   = mem[rd_addr];
                resp_strobe = 1'b1;
                strobe_q.push_back(cyc);
                rd_active = 1'b0;
            end else begin
                rd_wait--;
            end
        end else if (read_request) begin
            rd_active = 1'b1;
            rd_addr   = read_address;
            addr_q.push_back(read_address);
            rd_wait   = ((n_reads - rd_base) == stall_no) ? 2000 : int'($urandom_range(0, 6));
            n_reads++;
        end
    end

    int model_page = 0;

    task automatic wait_busy(input logic lvl, input int limit, input string tag);
        int k = 0;
        while (busy !== lvl && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " wait_busy"}, busy, lvl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_page = 0;
    endtask

    // Starts one frame and checks it against the expected word sequence.
    task automatic run_frame(input logic [15:0] wc, input logic [15:0] st, input logic [7:0] pc,
                             input logic [1:0] div, input int stall_at, input string tag);
        int a0, h0, r0, s0, nb, nr, lb, l0, l1, ll, pc_eff;
        logic [15:0] base, a, w;
        pc_eff = (pc == 8'd0) ? 1 : int'(pc);
        base = st + 16'(model_page) * wc;
        lb = 60 << div;  l0 = 17 << div;  l1 = 34 << div;  ll = TL << div;
        @(negedge clk);
        word_count = wc; start_address = st; page_count = pc; clock_divisor = div;
        stall_no = stall_at; rd_base = n_reads;
        a0 = addr_q.size(); h0 = high_q.size(); r0 = rise_q.size(); s0 = strobe_q.size();
        start_toggle = ~start_toggle;
        wait_busy(1'b1, 20, tag);
        wait_busy(1'b0, 16 * int'(wc) * lb + ll + 3000, tag);
        @(negedge clk);

        chk({tag, " reads"}, addr_q.size() - a0, wc);
        for (int i = 0; i < int'(wc) && a0 + i < addr_q.size(); i++)
            chk({tag, " addr"}, addr_q[a0 + i], 16'(base + 16'(i)));
        nb = high_q.size() - h0;
        nr = rise_q.size() - r0;
        chk({tag, " bits"}, nb, 16 * wc);
        for (int k = 0; k < nb && k < 16 * int'(wc); k++) begin
            a = base + 16'(k / 16);
            w = mem[a];
            chk({tag, " high"}, high_q[h0 + k], w[15 - (k % 16)] ? l1 : l0);
        end
        for (int k = 1; k < nr && k < 16 * int'(wc); k++) begin
            if (stall_at == 1 && k == 16) begin
                if (strobe_q.size() > s0 + 1)
                    chk({tag, " resume"}, rise_q[r0 + k] - strobe_q[s0 + 1], 1);
            end else begin
                chk({tag, " period"}, rise_q[r0 + k] - rise_q[r0 + k - 1], lb);
            end
        end
        if (nr > 0 && strobe_q.size() > s0) begin
            chk({tag, " latency"}, rise_q[r0] - strobe_q[s0], 1);
            chk({tag, " latch"}, busy_fall_cyc - rise_q[rise_q.size() - 1], lb + ll);
        end
        model_page = (model_page + 1 >= pc_eff) ? 0 : model_page + 1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_rises, snap_req, snap_rq, snap_reads;
        logic [15:0] r_wc;
        logic [7:0]  r_pc;

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0010] = 16'hA000;
        rst = 1'b1; word_count = 16'd0; start_address = 16'h0010; page_count = 8'd1;
        clock_divisor = 2'd0; start_toggle = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset data_out", data_out, 0);
        chk("reset read_request", read_request, 0);
        chk("reset busy", busy, 0);
        chk("reset read_address", read_address, 16'h0010);
        rst = 1'b0;

        run_frame(16'd1, 16'h0010, 8'd1, 2'd0, -1, "basic");

        do_reset();
        for (int f = 0; f < 3; f++) run_frame(16'd3, 16'h0010, 8'd2, 2'd0, -1, "page");

        do_reset();
        run_frame(16'd3, 16'h0200, 8'd1, 2'd0, 1, "stall");

        do_reset();
        run_frame(16'd1, 16'h0300, 8'd1, 2'd2, -1, "div2");

        do_reset();
        r_wc = 16'($urandom_range(1, 2));
        r_pc = 8'($urandom_range(0, 3));
        for (int f = 0; f < 4; f++)
            run_frame(r_wc, (f == 0) ? 16'hFFFF : 16'($urandom), r_pc,
                      2'($urandom_range(0, 1)), -1, "rand");

        // Reset in the middle of a word with the prefetch read outstanding.
        do_reset();
        word_count = 16'd2; start_address = 16'h0100; page_count = 8'd1; clock_divisor = 2'd0;
        stall_no = 1; rd_base = n_reads;
        start_toggle = ~start_toggle;
        for (int k = 0; k < 100 && !data_out; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("rstmid pre_request", read_request, 1);
        rst = 1'b1; resp_en = 1'b0;
        @(negedge clk);
        chk("rstmid data_out", data_out, 0);
        chk("rstmid read_request", read_request, 0);
        chk("rstmid busy", busy, 0);
        man_data = 16'hFFFF; man_strobe = 1'b1; start_toggle = ~start_toggle;
        @(negedge clk);
        man_strobe = 1'b0; rst = 1'b0;
        @(negedge clk);
        snap_rises = busy_rises; snap_req = req_cycles; snap_rq = rise_q.size();
        man_strobe = 1'b1;
        @(negedge clk);
        man_strobe = 1'b0;
        repeat (200) @(negedge clk);
        chk("rstmid no_frame", busy_rises - snap_rises, 0);
        chk("rstmid no_request", req_cycles - snap_req, 0);
        chk("rstmid no_pulse", rise_q.size() - snap_rq, 0);
        chk("rstmid read_address", read_address, 16'h0100);
        resp_en = 1'b1; model_page = 0;
        run_frame(16'd1, 16'h0100, 8'd1, 2'd0, -1, "after_rst");

        // Zero-length frame request is consumed without any bus activity.
        do_reset();
        snap_rises = busy_rises; snap_req = req_cycles;
        word_count = 16'd0;
        start_toggle = ~start_toggle;
        repeat (50) @(negedge clk);
        chk("wc0 busy", busy_rises - snap_rises, 0);
        chk("wc0 request", req_cycles - snap_req, 0);

        // Two edges while busy collapse into exactly one follow-up frame.
        snap_rises = busy_rises; snap_reads = n_reads; snap_rq = rise_q.size();
        word_count = 16'd1; start_address = 16'h0400; page_count = 8'd1; stall_no = -1;
        start_toggle = ~start_toggle;
        wait_busy(1'b1, 20, "twoedge");
        repeat (100) @(negedge clk);
        start_toggle = ~start_toggle;
        repeat (5) @(negedge clk);
        start_toggle = ~start_toggle;
        wait_busy(1'b0, 4000, "twoedge");
        wait_busy(1'b1, 20, "twoedge");
        wait_busy(1'b0, 4000, "twoedge");
        repeat (300) @(negedge clk);
        chk("twoedge frames", busy_rises - snap_rises, 2);
        chk("twoedge reads", n_reads - snap_reads, 2);
        chk("twoedge bits", rise_q.size() - snap_rq, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
